// File: rtl/upc_loop_profiler.sv
// upc_loop_profiler: cycle-accurate profiler for one ap_ctrl_hs loop/sub-module.
// Counts latency, retired iterations and stall cycles per invocation and queues
// one record per invocation in a small FIFO drained over a valid/ready port.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   loop_start/done/continue     ap_start / ap_done_int / ap_continue of the loop
//   iter_end_hit, stall          per-cycle iteration-retire and stall strobes
//   finish                       end of simulation; truncates a running invocation
//   rec_valid/rec_ready          record FIFO head handshake
//   rec_id/latency/iters/stalls/partial  head record fields (registered)
//   drop_cnt                     records lost to a full FIFO (saturating)
//   busy                         state is RUN or WAIT_CONT
module upc_loop_profiler #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned ID_W       = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             loop_start,
  input  logic             loop_done,
  input  logic             loop_continue,
  input  logic             iter_end_hit,
  input  logic             stall,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_iters,
  output logic [CNT_W-1:0] rec_stalls,
  output logic             rec_partial,
  output logic [15:0]      drop_cnt,
  output logic             busy
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_CONT, S_HALT} state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] iters;
    logic [CNT_W-1:0] stalls;
    logic             partial;
  } rec_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   lat_q, lat_d, iters_q, iters_d, stalls_q, stalls_d;
  logic [ID_W-1:0]    id_q, id_d;
  rec_t               mem_q [FIFO_DEPTH];
  rec_t               mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  rec_t               head_q, head_d;
  logic               rec_valid_q, rec_valid_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               busy_q, busy_d;

  logic               rec_form, push, pop;
  rec_t               new_rec;
  logic [CNT_W-1:0]   cur_lat, cur_iters, cur_stalls;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // Invocation tracking, record formation and FIFO next-state
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    iters_d     = iters_q;
    stalls_d    = stalls_q;
    id_d        = id_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    head_d      = head_q;
    rec_valid_d = rec_valid_q;
    drop_cnt_d  = drop_cnt_q;
    busy_d      = busy_q;
    rec_form    = 1'b0;
    new_rec     = '0;
    push        = 1'b0;
    pop         = 1'b0;

    // Counts as they stand including the current cycle
    cur_lat    = sat_inc(lat_q, 1'b1);
    cur_iters  = sat_inc(iters_q, iter_end_hit);
    cur_stalls = sat_inc(stalls_q, stall);

    unique case (state_q)
      S_IDLE: begin
        if (finish) begin
          state_d = S_HALT;
        end else if (loop_start) begin
          lat_d    = CNT_W'(1);
          iters_d  = CNT_W'(iter_end_hit);
          stalls_d = CNT_W'(stall);
          if (loop_done) begin
            rec_form = 1'b1;
            new_rec  = '{id: id_q, latency: CNT_W'(1), iters: CNT_W'(iter_end_hit),
                         stalls: CNT_W'(stall), partial: 1'b0};
            state_d  = loop_continue ? S_IDLE : S_WAIT_CONT;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        lat_d    = cur_lat;
        iters_d  = cur_iters;
        stalls_d = cur_stalls;
        if (loop_done || finish) begin
          // A done in the finish cycle still yields a complete record
          rec_form = 1'b1;
          new_rec  = '{id: id_q, latency: cur_lat, iters: cur_iters,
                       stalls: cur_stalls, partial: ~loop_done};
          if (finish)             state_d = S_HALT;
          else if (loop_continue) state_d = S_IDLE;
          else                    state_d = S_WAIT_CONT;
        end
      end
      S_WAIT_CONT: begin
        if (finish)             state_d = S_HALT;
        else if (loop_continue) state_d = S_IDLE;
      end
      default: state_d = S_HALT;
    endcase

    // Id advances per formed record, whether or not the FIFO takes it
    if (rec_form) id_d = id_q + ID_W'(1);

    // A full FIFO still accepts a record when the head leaves this cycle
    pop  = rec_valid_q & rec_ready;
    push = rec_form & ((occ_q != OCC_W'(FIFO_DEPTH)) | pop);
    if (rec_form && !push && (drop_cnt_q != {DROP_W{1'b1}}))
      drop_cnt_d = drop_cnt_q + DROP_W'(1);

    if (push) mem_d[wr_ptr_q] = new_rec;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    occ_d       = occ_q + OCC_W'(push) - OCC_W'(pop);
    // Head is re-registered from the post-update storage so outputs are flop-driven
    head_d      = mem_d[rd_ptr_d];
    rec_valid_d = (occ_d != '0);
    busy_d      = (state_d == S_RUN) || (state_d == S_WAIT_CONT);
  end

  // State and storage registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      iters_q     <= '0;
      stalls_q    <= '0;
      id_q        <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      head_q      <= '0;
      rec_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      iters_q     <= iters_d;
      stalls_q    <= stalls_d;
      id_q        <= id_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      rec_valid_q <= rec_valid_d;
      drop_cnt_q  <= drop_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign rec_valid   = rec_valid_q;
  assign rec_id      = head_q.id;
  assign rec_latency = head_q.latency;
  assign rec_iters   = head_q.iters;
  assign rec_stalls  = head_q.stalls;
  assign rec_partial = head_q.partial;
  assign drop_cnt    = drop_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_upc_loop_profiler.sv
// Testbench for upc_loop_profiler: directed invocations, expected records queued
// at stimulus time and compared by an independent monitor on each accepted record.
module tb_upc_loop_profiler;

  logic        clock;
  logic        reset;
  logic        loop_start, loop_done, loop_continue, iter_end_hit, stall, finish;
  logic        rec_valid, rec_ready;
  logic [15:0] rec_id;
  logic [31:0] rec_latency, rec_iters, rec_stalls;
  logic        rec_partial;
  logic [15:0] drop_cnt;
  logic        busy;

  typedef struct packed {
    logic [15:0] id;
    logic [31:0] lat;
    logic [31:0] it;
    logic [31:0] st;
    logic        part;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  upc_loop_profiler #(.CNT_W(32), .ID_W(16), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .loop_start(loop_start), .loop_done(loop_done), .loop_continue(loop_continue),
    .iter_end_hit(iter_end_hit), .stall(stall), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_id(rec_id), .rec_latency(rec_latency), .rec_iters(rec_iters),
    .rec_stalls(rec_stalls), .rec_partial(rec_partial),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic st, input logic dn, input logic cont,
                       input logic it, input logic sl, input logic fin);
    loop_start    = st;
    loop_done     = dn;
    loop_continue = cont;
    iter_end_hit  = it;
    stall         = sl;
    finish        = fin;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input int lat, input int it, input int st, input int part);
    exp_t e;
    e.id   = 16'(id);
    e.lat  = 32'(lat);
    e.it   = 32'(it);
    e.st   = 32'(st);
    e.part = 1'(part);
    exp_q.push_back(e);
  endtask

  // Monitor: every record accepted by the consumer must match the next expectation
  always @(negedge clock) begin
    if (!reset && rec_valid && rec_ready) begin
      exp_t got;
      exp_t e;
      got = '{id: rec_id, lat: rec_latency, it: rec_iters, st: rec_stalls, part: rec_partial};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got id=%0d lat=%0d it=%0d st=%0d part=%0d required none",
                 got.id, got.lat, got.it, got.st, got.part);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL record: got id=%0d lat=%0d it=%0d st=%0d part=%0d required id=%0d lat=%0d it=%0d st=%0d part=%0d",
                   got.id, got.lat, got.it, got.st, got.part, e.id, e.lat, e.it, e.st, e.part);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    rec_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("reset_valid", 64'(rec_valid), 64'd0);
    chk("reset_id", 64'(rec_id), 64'd0);
    chk("reset_latency", 64'(rec_latency), 64'd0);
    chk("reset_drop", 64'(drop_cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    step();

    // Single invocation: iterations retire at cycles 3..9
    push_exp(0, 10, 7, 0, 0);
    for (int c = 0; c < 10; c++) begin
      drive(c == 0, c == 9, 1'b1, c >= 3, 1'b0, 1'b0);
      step();
      if (c == 0) chk("t1_busy_run", 64'(busy), 64'd1);
      if (c == 8) chk("t1_valid_early", 64'(rec_valid), 64'd0);
      if (c == 9) chk("t1_valid_cycle10", 64'(rec_valid), 64'd1);
    end
    idle(3);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Stalls plus held continue; start during WAIT_CONT is ignored
    push_exp(1, 10, 7, 2, 0);
    for (int c = 0; c < 16; c++) begin
      drive(c == 0 || c == 12, c == 9, c >= 14, c >= 3 && c <= 9, c == 4 || c == 5, 1'b0);
      step();
      if (c == 11) chk("t2_busy_wait", 64'(busy), 64'd1);
      if (c == 13) chk("t2_busy_c14", 64'(busy), 64'd1);
      if (c == 14) chk("t2_busy_c15", 64'(busy), 64'd0);
    end
    idle(3);
    chk("t2_busy_after", 64'(busy), 64'd0);

    // Back-to-back invocations with loop_start held high
    push_exp(2, 5, 5, 0, 0);
    push_exp(3, 5, 5, 0, 0);
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, c == 4 || c == 9, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      if (c == 7) chk("t3_busy_second", 64'(busy), 64'd1);
    end
    idle(3);
    chk("t3_busy_after", 64'(busy), 64'd0);

    // Reset to restart ids
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Overflow: six single-cycle invocations into a stalled 4-deep FIFO
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_exp(i, 1, 1, 0, 0);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_drop", 64'(drop_cnt), 64'd2);
    chk("t4_valid_full", 64'(rec_valid), 64'd1);
    chk("t4_head_id", 64'(rec_id), 64'd0);
    step();
    step();
    chk("t4_head_hold", 64'(rec_id), 64'd0);
    chk("t4_head_lat_hold", 64'(rec_latency), 64'd1);
    rec_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t4_drained", 64'(rec_valid), 64'd0);
    push_exp(6, 1, 1, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    idle(3);

    // Finish mid-run: partial record, then everything is ignored
    push_exp(7, 6, 5, 1, 1);
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 1'b0, 1'b1, c >= 1, c == 2, c == 5);
      step();
    end
    idle(3);
    chk("t5_busy_halt", 64'(busy), 64'd0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    idle(2);
    chk("t5_halt_no_rec", 64'(rec_valid), 64'd0);
    chk("t5_halt_busy", 64'(busy), 64'd0);
    chk("t5_drop_kept", 64'(drop_cnt), 64'd2);

    // Reset mid-run discards the invocation and restarts ids
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_reset_drop", 64'(drop_cnt), 64'd0);
    for (int c = 0; c < 4; c++) begin
      reset = (c == 3);
      drive(c == 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    reset = 1'b0;
    chk("t6_busy_zero", 64'(busy), 64'd0);
    chk("t6_valid_zero", 64'(rec_valid), 64'd0);
    chk("t6_id_zero", 64'(rec_id), 64'd0);
    chk("t6_stalls_zero", 64'(rec_stalls), 64'd0);
    chk("t6_partial_zero", 64'(rec_partial), 64'd0);
    push_exp(0, 3, 3, 3, 0);
    for (int c = 0; c < 3; c++) begin
      drive(c == 0, c == 2, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    idle(3);

    chk("pending_records", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
